// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder that time-shares one 1-bit full adder cell behind a start/ready/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that computes a_in - b_in instead.

module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic             fa_s, fa_cout;
  logic             take, last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign take     = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (cnt == CW'(WIDTH - 1));
  // The collected bits plus the current sum bit form the full result on the last edge.
  assign res_next = {fa_s, res_sh};

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtraction: invert B and force the initial carry to one.
  assign b_load     = sub ? ~b_in : b_in;
  assign carry_load = sub ? 1'b1 : cin_in;
`else
  assign b_load     = b_in;
  assign carry_load = cin_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (take) begin
      a_sh    <= a_in;
      b_sh    <= b_load;
      carry_q <= carry_load;
      cnt     <= '0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      res_sh  <= res_next[WIDTH-1:1];
      carry_q <= fa_cout;
      cnt     <= cnt + 1'b1;
      // sum/cout keep showing the previous result until the final bit is in.
      if (last_bit) begin
        sum  <= res_next;
        cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed vectors feed a scoreboard queue,
// a negedge monitor pops and compares on every done pulse.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       cin_in;
  logic       sub;
  logic       ready, busy, done;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int n_pushed = 0;
  logic [8:0] sb[$];
  logic [8:0] last_exp = 9'h000;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .cin_in (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub    (sub),
`endif
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result_sum", {24'd0, sum}, {24'd0, e[7:0]});
          check("result_cout", {31'd0, cout}, {31'd0, e[8]});
          last_exp = e;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of RUN cycle 1.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                          input logic [7:0] exp_sum, input logic exp_cout, input bit push);
    a_in   = a;
    b_in   = b;
    cin_in = c;
    sub    = s;
    start  = 1'b1;
    if (push) begin
      sb.push_back({exp_cout, exp_sum});
      n_pushed++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge of RUN cycle 1; returns at the negedge of the following IDLE cycle.
  task automatic wait_done(input string name);
    int n = 1;
    int nb = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, 9);
    check({name, "_busy_cycles"}, nb, 8);
    @(negedge clk);
    check({name, "_ready_after"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1; sub = 1'b0;

    // Reset with start held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'h00);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_no_run", {31'd0, busy}, 32'd0);

    // Basic add and carry propagation
    start_op(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1);
    wait_done("add_05_03");
    start_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_done("add_ff_01");
    start_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_done("add_ff_ff_c");
    start_op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
    wait_done("add_80_80_c");

    // Ignored starts during RUN and DONE, sum held at previous result (0x01, cout 1)
    start_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) begin
        check("hold_busy", {31'd0, busy}, 32'd1);
        check("hold_result", {23'd0, cout, sum}, 32'h101);
      end
      if (c == 3) begin start = 1'b1; a_in = 8'hAA; b_in = 8'h55; end
      if (c == 4) start = 1'b0;
      if (c == 9) begin
        check("ign_done", {31'd0, done}, 32'd1);
        start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
      end
      @(negedge clk);
    end
    // First IDLE cycle: back-to-back start is accepted
    check("b2b_ready", {31'd0, ready}, 32'd1);
    start_op(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("add_11_22");

    // Reset mid-operation: no done, outputs cleared
    start_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'h00);
    check("abort_cout", {31'd0, cout}, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_idle", {31'd0, ready}, 32'd1);
    start_op(8'h02, 8'h02, 1'b0, 1'b0, 8'h04, 1'b0, 1'b1);
    wait_done("add_02_02");

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1);
    wait_done("sub_05_03");
    start_op(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b1);
    wait_done("sub_03_05");
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    check("done_count", done_seen, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
